// File: rtl/ulx3s_pll_lock_supervisor.sv
// Lock supervisor for an ECP5 EHXPLLL. It pulses PLL RST, waits for LOCK and checks that lock stays stable,
// then releases sys_rstn. It also detects loss of lock, retries failed locks and re-locks on request.
module ulx3s_pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int DROP_FILTER   = 4,
    parameter int MAX_RETRIES   = 7,
    parameter int CNT_W         = 17
) (
    input  logic       clkin,
    input  logic       rstn,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rstn,
    output logic       lock_ok,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] relock_count
);

    // relock_req is a single-cycle pulse with no acknowledge. It is sampled on every clkin edge and acted
    // on only in RUN or FAULT. In every other state it is dropped.
    localparam int RTRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int DROP_W = $clog2(DROP_FILTER + 1);

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [RTRY_W-1:0]  retries;
    logic [RTRY_W-1:0]  retries_n;
    logic [DROP_W-1:0]  drop;
    logic [DROP_W-1:0]  drop_n;
    logic               relock_inc;
    logic               drop_hit;
    logic               sync1;
    logic               sync2;
    logic               lock_s;

    // LOCK comes from the PLL's own timing domain, so it is resynchronised before any decision uses it.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pll_locked;
            sync2 <= sync1;
        end
    end

    assign lock_s   = sync2;
    assign drop_hit = !lock_s && (drop == DROP_W'(DROP_FILTER - 1));

    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt + CNT_W'(1);
        retries_n  = retries;
        drop_n     = drop;
        relock_inc = 1'b0;
        case (state_q)
            ST_PLL_RESET: begin
                if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                    state_n = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = ST_STABLE;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    if (retries == RTRY_W'(MAX_RETRIES)) begin
                        state_n = ST_FAULT;
                    end else begin
                        retries_n = retries + RTRY_W'(1);
                        state_n   = ST_PLL_RESET;
                    end
                end
            end
            ST_STABLE: begin
                // A single low sample throws away the whole stability window.
                if (!lock_s) begin
                    state_n = ST_WAIT_LOCK;
                end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_n = '0;
                if (lock_s) begin
                    drop_n = '0;
                end else begin
                    drop_n = drop + DROP_W'(1);
                end
                if (drop_hit) begin
                    relock_inc = 1'b1;
                    state_n    = ST_PLL_RESET;
                end
                if (relock_req) begin
                    retries_n = '0;
                    state_n   = ST_PLL_RESET;
                end
            end
            ST_FAULT: begin
                cnt_n = '0;
                if (relock_req) begin
                    retries_n = '0;
                    state_n   = ST_PLL_RESET;
                end
            end
            default: begin
                state_n = ST_PLL_RESET;
            end
        endcase
        if (state_n != state_q) begin
            cnt_n  = '0;
            drop_n = '0;
        end
        if (state_n == ST_RUN && state_q != ST_RUN) begin
            retries_n = '0;
        end
    end

    // The outputs are registered from the next state, so they always match the state register.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_PLL_RESET;
            cnt          <= '0;
            retries      <= '0;
            drop         <= '0;
            relock_count <= '0;
            pll_rst      <= 1'b1;
            sys_rstn     <= 1'b0;
            lock_ok      <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt      <= cnt_n;
            retries  <= retries_n;
            drop     <= drop_n;
            pll_rst  <= (state_n == ST_PLL_RESET);
            sys_rstn <= (state_n == ST_RUN);
            lock_ok  <= (state_n == ST_RUN);
            fault    <= (state_n == ST_FAULT);
            if (relock_inc && relock_count != 8'hFF) begin
                relock_count <= relock_count + 8'd1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_ulx3s_pll_lock_supervisor.sv
// Bench for ulx3s_pll_lock_supervisor: directed scenario tasks plus randomized traffic checked against
// a phase/elapsed-time reference model.
module tb_ulx3s_pll_lock_supervisor;

    localparam int RST_C = 4;
    localparam int TO_C  = 32;
    localparam int ST_C  = 8;
    localparam int DF_C  = 4;
    localparam int MR_C  = 2;

    logic       clkin = 1'b0;
    logic       rstn = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rstn;
    logic       lock_ok;
    logic       fault;
    logic [2:0] state;
    logic [7:0] relock_count;

    int tests_run = 0;
    int tests_failed = 0;

    ulx3s_pll_lock_supervisor #(
        .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TO_C), .STABLE_CYCLES(ST_C),
        .DROP_FILTER(DF_C), .MAX_RETRIES(MR_C), .CNT_W(17)
    ) dut (
        .clkin(clkin), .rstn(rstn), .pll_locked(pll_locked), .relock_req(relock_req),
        .pll_rst(pll_rst), .sys_rstn(sys_rstn), .lock_ok(lock_ok), .fault(fault),
        .state(state), .relock_count(relock_count)
    );

    always #5 clkin = ~clkin;

    // The reference model tracks a phase, the cycles elapsed in that phase, and the last two lock samples.
    localparam int M_RESET = 0, M_WAIT = 1, M_STABLE = 2, M_RUN = 3, M_FAULT = 4;
    int   m_phase = M_RESET;
    int   m_elapsed = 0;
    int   m_tries = 0;
    int   m_lows = 0;
    int   m_relocks = 0;
    logic m_seen1 = 1'b0;
    logic m_seen2 = 1'b0;

    always @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            m_phase   <= M_RESET;
            m_elapsed <= 0;
            m_tries   <= 0;
            m_lows    <= 0;
            m_relocks <= 0;
            m_seen1   <= 1'b0;
            m_seen2   <= 1'b0;
        end else begin : model_step
            int nxt, tr, lo, rc;
            nxt = m_phase;
            tr  = m_tries;
            lo  = m_lows;
            rc  = m_relocks;
            case (m_phase)
                M_RESET:  if (m_elapsed + 1 >= RST_C) nxt = M_WAIT;
                M_WAIT: begin
                    if (m_seen2) nxt = M_STABLE;
                    else if (m_elapsed + 1 >= TO_C) begin
                        if (tr >= MR_C) nxt = M_FAULT;
                        else begin tr = tr + 1; nxt = M_RESET; end
                    end
                end
                M_STABLE: begin
                    if (!m_seen2) nxt = M_WAIT;
                    else if (m_elapsed + 1 >= ST_C) begin nxt = M_RUN; tr = 0; end
                end
                M_RUN: begin
                    lo = m_seen2 ? 0 : lo + 1;
                    if (lo >= DF_C) begin
                        rc  = (rc < 255) ? rc + 1 : 255;
                        nxt = M_RESET;
                    end
                    if (relock_req) begin nxt = M_RESET; tr = 0; end
                end
                default:  if (relock_req) begin nxt = M_RESET; tr = 0; end
            endcase
            m_elapsed <= (nxt == m_phase) ? m_elapsed + 1 : 0;
            m_lows    <= (nxt == m_phase) ? lo : 0;
            m_phase   <= nxt;
            m_tries   <= tr;
            m_relocks <= rc;
            m_seen2   <= m_seen1;
            m_seen1   <= pll_locked;
        end
    end

    task automatic test_reset();
        rstn = 1'b0; pll_locked = 1'b0; relock_req = 1'b0;
        repeat (3) @(negedge clkin);
        tests_run++; if (pll_rst !== 1'b1) begin tests_failed++; $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); end
        tests_run++; if (sys_rstn !== 1'b0) begin tests_failed++; $display("FAIL reset_sys_rstn: got %b expected 0", sys_rstn); end
        tests_run++; if (lock_ok !== 1'b0) begin tests_failed++; $display("FAIL reset_lock_ok: got %b expected 0", lock_ok); end
        tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault: got %b expected 0", fault); end
        tests_run++; if (state !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", state); end
        tests_run++; if (relock_count !== 8'd0) begin tests_failed++; $display("FAIL reset_relock_count: got %0d expected 0", relock_count); end
    endtask

    task automatic test_lock_sequence();
        int n;
        rstn = 1'b1;
        n = 0;
        do begin @(posedge clkin); #1; n++; end while (pll_rst !== 1'b0 && n < 50);
        tests_run++; if (n != RST_C) begin tests_failed++; $display("FAIL lock_rst_width: got %0d cycles expected %0d", n, RST_C); end
        repeat (10) @(posedge clkin);
        @(negedge clkin); pll_locked = 1'b1;
        n = 0;
        do begin @(posedge clkin); #1; n++; end while (sys_rstn !== 1'b1 && n < 100);
        tests_run++; if (n != ST_C + 3) begin tests_failed++; $display("FAIL lock_release_latency: got %0d cycles expected %0d", n, ST_C + 3); end
        tests_run++; if (state !== 3'd3) begin tests_failed++; $display("FAIL lock_state: got %0d expected 3", state); end
        tests_run++; if (lock_ok !== 1'b1) begin tests_failed++; $display("FAIL lock_lock_ok: got %b expected 1", lock_ok); end
        tests_run++; if (pll_rst !== 1'b0) begin tests_failed++; $display("FAIL lock_pll_rst: got %b expected 0", pll_rst); end
    endtask

    task automatic test_glitch_filter();
        int n;
        bit left_run;
        @(negedge clkin); pll_locked = 1'b0;
        repeat (3) @(negedge clkin); pll_locked = 1'b1;
        left_run = 1'b0;
        repeat (12) begin
            @(posedge clkin); #1;
            if (sys_rstn !== 1'b1 || state !== 3'd3) left_run = 1'b1;
        end
        tests_run++; if (left_run) begin tests_failed++; $display("FAIL glitch_short_ignored: got left RUN expected stay in RUN"); end
        tests_run++; if (relock_count !== 8'd0) begin tests_failed++; $display("FAIL glitch_short_count: got %0d expected 0", relock_count); end
        @(negedge clkin); pll_locked = 1'b0;
        repeat (5) @(negedge clkin); pll_locked = 1'b1;
        n = 0;
        do begin @(posedge clkin); #1; n++; end while (sys_rstn !== 1'b0 && n < 20);
        tests_run++; if (n != 1) begin tests_failed++; $display("FAIL glitch_drop_edge: got %0d expected 1", n); end
        tests_run++; if (pll_rst !== 1'b1) begin tests_failed++; $display("FAIL glitch_drop_pll_rst: got %b expected 1", pll_rst); end
        tests_run++; if (relock_count !== 8'd1) begin tests_failed++; $display("FAIL glitch_drop_count: got %0d expected 1", relock_count); end
        n = 0;
        do begin @(posedge clkin); #1; n++; end while (pll_rst !== 1'b0 && n < 20);
        tests_run++; if (n != RST_C) begin tests_failed++; $display("FAIL glitch_rst_width: got %0d expected %0d", n, RST_C); end
        n = 0;
        do begin @(posedge clkin); #1; n++; end while (sys_rstn !== 1'b1 && n < 100);
        tests_run++; if (state !== 3'd3) begin tests_failed++; $display("FAIL glitch_rerun_state: got %0d expected 3", state); end
    endtask

    task automatic test_stable_glitch();
        int n;
        bit early_release;
        @(negedge clkin); rstn = 1'b0; pll_locked = 1'b0;
        @(negedge clkin); rstn = 1'b1;
        n = 0;
        do begin @(posedge clkin); #1; n++; end while (pll_rst !== 1'b0 && n < 20);
        @(negedge clkin); pll_locked = 1'b1;
        n = 0;
        do begin @(posedge clkin); #1; n++; end while (state !== 3'd2 && n < 20);
        repeat (3) @(posedge clkin);
        @(negedge clkin); pll_locked = 1'b0;
        @(negedge clkin); pll_locked = 1'b1;
        early_release = 1'b0;
        n = 0;
        do begin @(posedge clkin); #1; n++; if (sys_rstn !== 1'b0) early_release = 1'b1; end
        while (state !== 3'd1 && n < 20);
        tests_run++; if (state !== 3'd1) begin tests_failed++; $display("FAIL stable_back_to_wait: got %0d expected 1", state); end
        n = 0;
        do begin @(posedge clkin); #1; n++; end while (state !== 3'd2 && n < 20);
        n = 0;
        do begin
            @(posedge clkin); #1; n++;
            if (state !== 3'd3 && sys_rstn !== 1'b0) early_release = 1'b1;
        end while (state !== 3'd3 && n < 40);
        tests_run++; if (n != ST_C) begin tests_failed++; $display("FAIL stable_window_restart: got %0d expected %0d", n, ST_C); end
        tests_run++; if (early_release) begin tests_failed++; $display("FAIL stable_sys_rstn_held: got early release expected 0 until RUN"); end
    endtask

    task automatic test_retry_fault();
        int starts[$];
        int first_fault;
        int s1, s2;
        logic prev;
        bit rst_in_fault;
        @(negedge clkin); rstn = 1'b0; pll_locked = 1'b0; relock_req = 1'b0;
        @(negedge clkin); rstn = 1'b1;
        starts.push_back(0);
        prev = 1'b1;
        first_fault = -1;
        rst_in_fault = 1'b0;
        for (int n = 1; n <= 170; n++) begin
            @(posedge clkin); #1;
            if (pll_rst === 1'b1 && prev === 1'b0) starts.push_back(n);
            prev = pll_rst;
            if (fault === 1'b1 && first_fault < 0) first_fault = n;
            if (fault === 1'b1 && pll_rst !== 1'b0) rst_in_fault = 1'b1;
        end
        s1 = (starts.size() > 1) ? starts[1] : -1;
        s2 = (starts.size() > 2) ? starts[2] : -1;
        tests_run++; if (starts.size() != 3) begin tests_failed++; $display("FAIL retry_pulse_count: got %0d expected 3", starts.size()); end
        tests_run++; if (s1 != RST_C + TO_C) begin tests_failed++; $display("FAIL retry_second_pulse: got %0d expected %0d", s1, RST_C + TO_C); end
        tests_run++; if (s2 != 2 * (RST_C + TO_C)) begin tests_failed++; $display("FAIL retry_third_pulse: got %0d expected %0d", s2, 2 * (RST_C + TO_C)); end
        tests_run++; if (first_fault != 3 * (RST_C + TO_C)) begin tests_failed++; $display("FAIL retry_fault_time: got %0d expected %0d", first_fault, 3 * (RST_C + TO_C)); end
        tests_run++; if (state !== 3'd4) begin tests_failed++; $display("FAIL retry_fault_state: got %0d expected 4", state); end
        tests_run++; if (rst_in_fault || pll_rst !== 1'b0) begin tests_failed++; $display("FAIL retry_fault_pll_rst: got %b expected 0", pll_rst); end
    endtask

    task automatic test_relock_req();
        int n;
        @(negedge clkin); relock_req = 1'b1;
        @(negedge clkin); relock_req = 1'b0;
        tests_run++; if (state !== 3'd0) begin tests_failed++; $display("FAIL relock_fault_state: got %0d expected 0", state); end
        tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL relock_fault_clear: got %b expected 0", fault); end
        n = 0;
        do begin @(posedge clkin); #1; n++; end while (pll_rst !== 1'b0 && n < 20);
        n = 0;
        do begin @(posedge clkin); #1; n++; end while (pll_rst !== 1'b1 && fault !== 1'b1 && n < 60);
        tests_run++; if (n != TO_C || fault !== 1'b0) begin tests_failed++; $display("FAIL relock_retries_cleared: got n=%0d fault=%b expected n=%0d fault=0", n, fault, TO_C); end
        n = 0;
        do begin @(posedge clkin); #1; n++; end while (pll_rst !== 1'b0 && n < 20);
        @(negedge clkin); relock_req = 1'b1;
        @(negedge clkin); relock_req = 1'b0;
        tests_run++; if (state !== 3'd1 || pll_rst !== 1'b0) begin tests_failed++; $display("FAIL relock_wait_ignored: got state=%0d pll_rst=%b expected state=1 pll_rst=0", state, pll_rst); end
        @(negedge clkin); pll_locked = 1'b1;
        n = 0;
        do begin @(posedge clkin); #1; n++; end while (sys_rstn !== 1'b1 && n < 60);
        @(negedge clkin); relock_req = 1'b1;
        @(negedge clkin); relock_req = 1'b0;
        tests_run++; if (pll_rst !== 1'b1 || sys_rstn !== 1'b0) begin tests_failed++; $display("FAIL relock_run_pulse: got pll_rst=%b sys_rstn=%b expected 1/0", pll_rst, sys_rstn); end
        tests_run++; if (relock_count !== 8'd0) begin tests_failed++; $display("FAIL relock_run_count: got %0d expected 0", relock_count); end
        n = 0;
        do begin @(posedge clkin); #1; n++; end while (pll_rst !== 1'b0 && n < 20);
        tests_run++; if (n != RST_C) begin tests_failed++; $display("FAIL relock_run_width: got %0d expected %0d", n, RST_C); end
        n = 0;
        do begin @(posedge clkin); #1; n++; end while (sys_rstn !== 1'b1 && n < 60);
        tests_run++; if (lock_ok !== 1'b1) begin tests_failed++; $display("FAIL relock_back_in_run: got %b expected 1", lock_ok); end
    endtask

    task automatic test_async_reset();
        int n;
        @(negedge clkin); pll_locked = 1'b0;
        repeat (5) @(negedge clkin); pll_locked = 1'b1;
        n = 0;
        do begin @(posedge clkin); #1; n++; end while (sys_rstn !== 1'b1 && n < 60);
        tests_run++; if (relock_count !== 8'd1) begin tests_failed++; $display("FAIL async_pre_count: got %0d expected 1", relock_count); end
        @(negedge clkin); #2; rstn = 1'b0; #1;
        tests_run++; if (pll_rst !== 1'b1) begin tests_failed++; $display("FAIL async_pll_rst: got %b expected 1", pll_rst); end
        tests_run++; if (sys_rstn !== 1'b0) begin tests_failed++; $display("FAIL async_sys_rstn: got %b expected 0", sys_rstn); end
        tests_run++; if (relock_count !== 8'd0) begin tests_failed++; $display("FAIL async_relock_count: got %0d expected 0", relock_count); end
        tests_run++; if (state !== 3'd0) begin tests_failed++; $display("FAIL async_state: got %0d expected 0", state); end
        @(negedge clkin); rstn = 1'b1;
    endtask

    task automatic test_random();
        int run_left;
        int rst_hold;
        run_left = 0;
        rst_hold = 0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clkin);
            tests_run++; if (pll_rst !== (m_phase == M_RESET)) begin tests_failed++; $display("FAIL rand_pll_rst @%0d: got %b expected %b", i, pll_rst, m_phase == M_RESET); end
            tests_run++; if (sys_rstn !== (m_phase == M_RUN)) begin tests_failed++; $display("FAIL rand_sys_rstn @%0d: got %b expected %b", i, sys_rstn, m_phase == M_RUN); end
            tests_run++; if (lock_ok !== (m_phase == M_RUN)) begin tests_failed++; $display("FAIL rand_lock_ok @%0d: got %b expected %b", i, lock_ok, m_phase == M_RUN); end
            tests_run++; if (fault !== (m_phase == M_FAULT)) begin tests_failed++; $display("FAIL rand_fault @%0d: got %b expected %b", i, fault, m_phase == M_FAULT); end
            tests_run++; if (state !== 3'(m_phase)) begin tests_failed++; $display("FAIL rand_state @%0d: got %0d expected %0d", i, state, m_phase); end
            tests_run++; if (relock_count !== 8'(m_relocks)) begin tests_failed++; $display("FAIL rand_relock_count @%0d: got %0d expected %0d", i, relock_count, m_relocks); end
            if (run_left == 0) begin
                if ($urandom_range(0, 99) < 65) begin
                    pll_locked = 1'b1;
                    run_left = $urandom_range(5, 60);
                end else begin
                    pll_locked = 1'b0;
                    run_left = ($urandom_range(0, 99) < 70) ? $urandom_range(1, 6) : $urandom_range(30, 150);
                end
            end
            run_left--;
            relock_req = ($urandom_range(0, 99) < 3);
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rstn = 1'b1;
            end else if ($urandom_range(0, 999) < 2) begin
                rstn = 1'b0;
                rst_hold = 2;
            end
        end
        @(negedge clkin); relock_req = 1'b0; rstn = 1'b1;
    endtask

    initial begin
        #1 rstn = 1'b0;
        test_reset();
        test_lock_sequence();
        test_glitch_filter();
        test_stable_glitch();
        test_retry_fault();
        test_relock_req();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, run %0d failed %0d", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

endmodule
